pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of the PC and all address ports.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000: PC value held from reset through BOOT.
REQ-003 SHALL have parameter TRAP_VEC, default 32'h0000_0100: redirect target for trap and misaligned-branch events.
REQ-004 SHALL have parameter INC, default 4: instruction size in bytes; legal values are 2 and 4.
REQ-005 SHALL have input clk_pc, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have input rst_pc_n, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have input stall, 1 bit: hold the PC this cycle.
REQ-008 SHALL have input br_taken, 1 bit: branch/jump redirect request.
REQ-009 SHALL have input br_target, XLEN bits: redirect address, valid when br_taken=1.
REQ-010 SHALL have input trap_req, 1 bit: exception request.
REQ-011 SHALL have input halt_req, 1 bit: enter HALT.
REQ-012 SHALL have input resume, 1 bit: leave HALT.
REQ-013 SHALL have output pc, XLEN bits, registered: current fetch address.
REQ-014 SHALL have output pc_inc, XLEN bits, combinational: pc + INC.
REQ-015 SHALL have output pc_valid, 1 bit, registered: pc is a fetchable address.
REQ-016 SHALL have output epc, XLEN bits, registered: PC captured on the last trap.
REQ-017 SHALL have output misalign_err, 1 bit, registered: one-cycle pulse on a misaligned branch.
REQ-018 SHALL have output halted, 1 bit, registered: 1 exactly when state is HALT.

Function
REQ-019 SHALL implement a state machine with states BOOT, RUN and HALT.
REQ-020 SHALL go BOOT -> RUN on the first rising edge after reset release, unconditionally; in BOOT, pc = RESET_VEC and pc_valid = 0; all inputs ignored.
REQ-021 SHALL compute pc_inc = (pc + INC) mod 2^XLEN; wrap from all-ones region to 0 is legal and silent.
REQ-022 SHALL, in RUN, select the next PC by priority: trap_req > misaligned br_taken > halt_req > aligned br_taken > stall > increment.
REQ-023 SHALL on trap_req: pc <= TRAP_VEC, epc <= current pc, remain or go to RUN.
REQ-024 SHALL treat br_taken with br_target[log2(INC)-1:0] != 0 as misaligned: pc <= TRAP_VEC, epc <= current pc, misalign_err = 1 for the next cycle only.
REQ-025 SHALL on halt_req (no trap/misalign): go to HALT, hold pc, pc_valid <= 0; any concurrent branch is discarded.
REQ-026 SHALL on aligned br_taken: pc <= br_target; br_taken overrides stall.
REQ-027 SHALL on stall alone: hold pc; pc_valid stays 1.
REQ-028 SHALL otherwise: pc <= pc + INC.
REQ-029 SHALL in HALT: hold pc, ignore br_taken, stall and halt_req; resume -> RUN with pc unchanged, pc_valid <= 1; trap_req -> RUN with the REQ-023 effects and wins over resume.
REQ-030 SHALL keep pc_valid = 1 in every RUN cycle and 0 in BOOT and HALT.
REQ-031 SHALL leave epc unchanged except on trap or misaligned-branch events.

Reset
REQ-032 SHALL on rst_pc_n = 0, immediately and independent of clk_pc: state = BOOT, pc = RESET_VEC, epc = 0, pc_valid = 0, misalign_err = 0, halted = 0.
REQ-033 SHALL, on reset assertion mid-operation, including HALT or a pending redirect, abandon all state and restart from BOOT on release.

Verification
REQ-034 Reset release, no inputs -> pc = 0 for 2 edges (BOOT), pc_valid 0 -> 1, then pc = 4, 8, 12 on successive edges.
REQ-035 pc = 0x40 in RUN, br_taken = 1, br_target = 0x200, stall = 1 same cycle -> next pc = 0x200, pc_inc = 0x204.
REQ-036 pc = 0x80, br_taken = 1, br_target = 0x202 (INC = 4) -> next pc = 0x100, epc = 0x80, misalign_err high for exactly one cycle.
REQ-037 halt_req at pc = 0x10 -> halted = 1, pc_valid = 0, pc holds 0x10 for N cycles despite br_taken; resume -> pc_valid = 1, then pc = 0x14.
REQ-038 pc = 0xFFFF_FFFC, no events -> next pc = 0x0000_0000; trap_req with halt_req and br_taken together -> pc = 0x100, epc = previous pc, halted stays 0.
REQ-039 rst_pc_n pulsed low between clock edges while in HALT -> outputs take reset values before the next edge; BOOT sequence repeats per REQ-034.

Source files
------------

// File: rtl/pc_gen.sv
// Program counter generator: BOOT/RUN/HALT sequencing with trap, branch,
// misaligned-branch, halt and stall handling for the fetch stage.
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
    parameter int              INC       = 4
) (
    input  logic            clk_pc,
    input  logic            rst_pc_n,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            trap_req,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_inc,
    output logic            pc_valid,
    output logic [XLEN-1:0] epc,
    output logic            misalign_err,
    output logic            halted
);

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);
    localparam logic [XLEN-1:0] INC_VAL    = XLEN'(INC);

    state_t          state_r;
    state_t          state_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_s;
    logic [XLEN-1:0] epc_r;
    logic [XLEN-1:0] epc_s;
    logic [XLEN-1:0] pc_inc_s;
    logic            pc_valid_r;
    logic            misalign_r;
    logic            misalign_s;
    logic            halted_r;

    // Low address bits below the instruction size must be zero for a legal target.
    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        is_aligned = ((addr & ALIGN_MASK) == {XLEN{1'b0}});
    endfunction

    assign pc_inc_s = pc_r + INC_VAL;

    // Next-state and next-PC selection; events are checked in strict priority order.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        epc_s      = epc_r;
        misalign_s = 1'b0;
        case (state_r)
            BOOT: begin
                state_s = RUN;
                pc_s    = RESET_VEC;
            end
            RUN: begin
                if (trap_req) begin
                    pc_s  = TRAP_VEC;
                    epc_s = pc_r;
                end else if (br_taken && !is_aligned(br_target)) begin
                    pc_s       = TRAP_VEC;
                    epc_s      = pc_r;
                    misalign_s = 1'b1;
                end else if (halt_req) begin
                    state_s = HALT;
                end else if (br_taken) begin
                    pc_s = br_target;
                end else if (stall) begin
                    pc_s = pc_r;
                end else begin
                    pc_s = pc_inc_s;
                end
            end
            HALT: begin
                // A trap while halted wakes the core straight into the handler.
                if (trap_req) begin
                    state_s = RUN;
                    pc_s    = TRAP_VEC;
                    epc_s   = pc_r;
                end else if (resume) begin
                    state_s = RUN;
                end else begin
                    state_s = HALT;
                end
            end
            default: begin
                state_s = BOOT;
                pc_s    = RESET_VEC;
            end
        endcase
    end

    // State and output registers; status flags follow the state being entered.
    always_ff @(posedge clk_pc or negedge rst_pc_n) begin
        if (!rst_pc_n) begin
            state_r    <= BOOT;
            pc_r       <= RESET_VEC;
            epc_r      <= {XLEN{1'b0}};
            pc_valid_r <= 1'b0;
            misalign_r <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            epc_r      <= epc_s;
            pc_valid_r <= (state_s == RUN);
            misalign_r <= misalign_s;
            halted_r   <= (state_s == HALT);
        end
    end

    assign pc           = pc_r;
    assign pc_inc       = pc_inc_s;
    assign pc_valid     = pc_valid_r;
    assign epc          = epc_r;
    assign misalign_err = misalign_r;
    assign halted       = halted_r;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with hand-computed expectations.
module tb_pc_gen;

    logic        clk_pc;
    logic        rst_pc_n;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        trap_req;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_inc;
    logic        pc_valid;
    logic [31:0] epc;
    logic        misalign_err;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    pc_gen #(
        .XLEN      (32),
        .RESET_VEC (32'h0000_0000),
        .TRAP_VEC  (32'h0000_0100),
        .INC       (4)
    ) dut (
        .clk_pc       (clk_pc),
        .rst_pc_n     (rst_pc_n),
        .stall        (stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .trap_req     (trap_req),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc           (pc),
        .pc_inc       (pc_inc),
        .pc_valid     (pc_valid),
        .epc          (epc),
        .misalign_err (misalign_err),
        .halted       (halted)
    );

    initial clk_pc = 1'b0;
    always #5 clk_pc = ~clk_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1ns after the rising edge.
    task automatic cyc(input logic st, input logic br, input logic [31:0] tgt,
                       input logic tr, input logic hl, input logic rs);
        stall     = st;
        br_taken  = br;
        br_target = tgt;
        trap_req  = tr;
        halt_req  = hl;
        resume    = rs;
        @(posedge clk_pc);
        #1;
    endtask

    initial begin
        rst_pc_n  = 1'b0;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'h0;
        trap_req  = 1'b0;
        halt_req  = 1'b0;
        resume    = 1'b0;
        #12;
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'b0, pc_valid}, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_mis", {31'b0, misalign_err}, 32'h0);
        chk("rst_pc_inc", pc_inc, 32'h4);
        rst_pc_n = 1'b1;

        // BOOT exit then sequential fetch
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("boot_pc", pc, 32'h0);
        chk("boot_valid", {31'b0, pc_valid}, 32'h1);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            chk("seq_pc", pc, 32'(4 * i));
        end

        // branch overrides stall
        cyc(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        chk("br40_pc", pc, 32'h40);
        cyc(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        chk("brstall_pc", pc, 32'h200);
        chk("brstall_inc", pc_inc, 32'h204);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("stall_pc", pc, 32'h200);
        chk("stall_valid", {31'b0, pc_valid}, 32'h1);

        // misaligned branch
        cyc(1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
        chk("br80_pc", pc, 32'h80);
        cyc(1'b0, 1'b1, 32'h202, 1'b0, 1'b0, 1'b0);
        chk("mis_pc", pc, 32'h100);
        chk("mis_epc", epc, 32'h80);
        chk("mis_err", {31'b0, misalign_err}, 32'h1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("mis_err_clr", {31'b0, misalign_err}, 32'h0);
        chk("mis_next_pc", pc, 32'h104);
        chk("mis_epc_hold", epc, 32'h80);

        // halt with concurrent branch, inputs ignored while halted, resume
        cyc(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 32'h300, 1'b0, 1'b1, 1'b0);
        chk("halt_halted", {31'b0, halted}, 32'h1);
        chk("halt_valid", {31'b0, pc_valid}, 32'h0);
        chk("halt_pc", pc, 32'h10);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 32'h300, 1'b0, 1'b1, 1'b0);
            chk("halt_hold_pc", pc, 32'h10);
            chk("halt_hold_h", {31'b0, halted}, 32'h1);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("resume_pc", pc, 32'h10);
        chk("resume_valid", {31'b0, pc_valid}, 32'h1);
        chk("resume_halted", {31'b0, halted}, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("resume_next", pc, 32'h14);

        // wrap at top of address space
        cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        chk("top_pc", pc, 32'hFFFF_FFFC);
        chk("top_inc", pc_inc, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("wrap_pc", pc, 32'h0);

        // trap beats halt and branch
        cyc(1'b0, 1'b1, 32'h500, 1'b1, 1'b1, 1'b0);
        chk("trap_pc", pc, 32'h100);
        chk("trap_epc", epc, 32'h0);
        chk("trap_halted", {31'b0, halted}, 32'h0);
        chk("trap_mis", {31'b0, misalign_err}, 32'h0);

        // misaligned branch beats halt
        cyc(1'b0, 1'b1, 32'h202, 1'b0, 1'b1, 1'b0);
        chk("mishalt_pc", pc, 32'h100);
        chk("mishalt_epc", epc, 32'h100);
        chk("mishalt_err", {31'b0, misalign_err}, 32'h1);
        chk("mishalt_halted", {31'b0, halted}, 32'h0);

        // trap wins over resume while halted
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("inc_pc", pc, 32'h104);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("halt2_pc", pc, 32'h104);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("htrap_pc", pc, 32'h100);
        chk("htrap_epc", epc, 32'h104);
        chk("htrap_valid", {31'b0, pc_valid}, 32'h1);
        chk("htrap_halted", {31'b0, halted}, 32'h0);

        // asynchronous reset while halted
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("halt3_halted", {31'b0, halted}, 32'h1);
        halt_req = 1'b0;
        #2;
        rst_pc_n = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_valid", {31'b0, pc_valid}, 32'h0);
        chk("arst_halted", {31'b0, halted}, 32'h0);
        chk("arst_epc", epc, 32'h0);
        #1;
        rst_pc_n = 1'b1;
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("reboot_pc", pc, 32'h0);
        chk("reboot_valid", {31'b0, pc_valid}, 32'h1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("reboot_pc4", pc, 32'h4);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("reboot_pc8", pc, 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
